label_loader: RTL and testbench

//   Write side of the label RAM. Accepts a byte stream of ground-truth class labels

---
 rtl/label_loader_if.sv | 34 +++
 rtl/label_loader.sv | 94 +++++++++
 tb/tb_label_loader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/label_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : label_loader_if
//  Description : Label byte stream handshake plus label RAM write port and
//                load status, bundled between the byte source and the loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface label_loader_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic              busy;
    logic              done;
    logic              err_range;
    logic [ADDR_W:0]   count;
    logic [15:0]       checksum;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, wr_addr, wr_data, wr_en, busy, done, err_range, count, checksum
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, wr_addr, wr_data, wr_en, busy, done, err_range, count, checksum
    );
endinterface
`default_nettype wire

// File: rtl/label_loader.sv
`default_nettype none
// ============================================================================
//  Module      : label_loader
//  Description : Write side of the label RAM: streams label bytes into the RAM
//                from address 0, tracking count, checksum and range errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module label_loader #(
    parameter int NUM_LABELS = 512,
    parameter int ADDR_W     = 9,
    parameter int CLASSES    = 10
) (
    input  wire             clk,
    input  wire             rst,
    label_loader_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W:0] C_LAST_CNT = (ADDR_W+1)'(NUM_LABELS - 1);
    localparam logic [8:0]      C_CLASSES  = 9'(CLASSES);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_wr_en;
    logic              r_err_range;
    logic [ADDR_W:0]   r_count;
    logic [15:0]       r_checksum;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_out_of_range;

    // A start pulse always wins over data in the same cycle, so the restart
    // never races with a byte being consumed.
    assign w_in_ready     = (r_state == S_LOAD) && !bus.start;
    assign w_accept       = bus.in_valid && w_in_ready;
    assign w_out_of_range = ({1'b0, bus.in_data} >= C_CLASSES);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_err_range <= 1'b0;
            r_count     <= '0;
            r_checksum  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (bus.start) begin
                r_state     <= S_LOAD;
                r_err_range <= 1'b0;
                r_count     <= '0;
                r_checksum  <= '0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (w_accept) begin
                            r_wr_en     <= 1'b1;
                            r_wr_addr   <= r_count[ADDR_W-1:0];
                            r_wr_data   <= bus.in_data;
                            r_count     <= r_count + 1'b1;
                            r_checksum  <= r_checksum + {8'd0, bus.in_data};
                            r_err_range <= r_err_range | w_out_of_range;
                            if (r_count == C_LAST_CNT) begin
                                r_state <= S_DONE;
                            end
                        end
                    end
                    S_IDLE, S_DONE: begin
                        r_state <= r_state;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.wr_en     = r_wr_en;
    assign bus.busy      = (r_state == S_LOAD);
    assign bus.done      = (r_state == S_DONE);
    assign bus.err_range = r_err_range;
    assign bus.count     = r_count;
    assign bus.checksum  = r_checksum;
endmodule
`default_nettype wire

// File: tb/tb_label_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_label_loader
//  Description : Self-checking bench for label_loader with a 4-label load.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_label_loader;
    localparam int N    = 4;
    localparam int AW   = 2;
    localparam int NCLS = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    label_loader_if #(.ADDR_W(AW)) bus ();

    label_loader #(.NUM_LABELS(N), .ADDR_W(AW), .CLASSES(NCLS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] ram [0:N-1];
    always @(posedge clk) if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a load is a list of accepted bytes; status is derived from it.
    bit         m_loading, m_done, m_wen, m_err;
    int         m_cnt, m_sum;
    int         m_waddr, m_wdata;
    logic [7:0] m_ram [0:N-1];

    typedef struct {
        logic        st;
        logic        vl;
        logic [7:0]  d;
        logic        e_wen;
        logic [1:0]  e_addr;
        logic [7:0]  e_data;
        logic        e_done;
        logic [2:0]  e_cnt;
        logic [15:0] e_sum;
        logic        e_err;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_loading = 0; m_done = 0; m_wen = 0; m_err = 0;
        m_cnt = 0; m_sum = 0; m_waddr = 0; m_wdata = 0;
    endtask

    task automatic check_outputs();
        chk("wr_en",     {31'd0, bus.wr_en},     {31'd0, m_wen});
        chk("wr_addr",   {30'd0, bus.wr_addr},   m_waddr);
        chk("wr_data",   {24'd0, bus.wr_data},   m_wdata);
        chk("busy",      {31'd0, bus.busy},      {31'd0, m_loading});
        chk("done",      {31'd0, bus.done},      {31'd0, m_done});
        chk("err_range", {31'd0, bus.err_range}, {31'd0, m_err});
        chk("count",     {29'd0, bus.count},     m_cnt);
        chk("checksum",  {16'd0, bus.checksum},  m_sum & 32'hFFFF);
    endtask

    // Called at a negedge: apply inputs, check in_ready, advance model, check results.
    task automatic cycle(input logic st, input logic vl, input logic [7:0] d);
        bit acc;
        bus.start = st; bus.in_valid = vl; bus.in_data = d;
        #1;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_loading && !st});
        acc = vl && m_loading && !st;
        m_wen = 0;
        if (st) begin
            m_loading = 1; m_done = 0; m_cnt = 0; m_sum = 0; m_err = 0;
        end else if (acc) begin
            m_wen = 1; m_waddr = m_cnt; m_wdata = d; m_ram[m_cnt] = d;
            m_cnt++; m_sum = (m_sum + d) % 65536;
            if (d >= NCLS) m_err = 1;
            if (m_cnt == N) begin m_loading = 0; m_done = 1; end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h05;
        @(negedge clk);
        model_reset();
        rst = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
        check_outputs();
    endtask

    initial begin
        bus.start = 0; bus.in_valid = 0; bus.in_data = 0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Idle with valid data and no start: nothing consumed.
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 8'h03);

        // Back-to-back load, 5th byte refused, then reload of 0xFF bytes from DONE.
        tbl[0]  = '{1,0,8'h00, 0,2'd0,8'h00, 0,3'd0,16'h0000, 0};
        tbl[1]  = '{0,1,8'h03, 1,2'd0,8'h03, 0,3'd1,16'h0003, 0};
        tbl[2]  = '{0,1,8'h01, 1,2'd1,8'h01, 0,3'd2,16'h0004, 0};
        tbl[3]  = '{0,1,8'h04, 1,2'd2,8'h04, 0,3'd3,16'h0008, 0};
        tbl[4]  = '{0,1,8'h01, 1,2'd3,8'h01, 1,3'd4,16'h0009, 0};
        tbl[5]  = '{0,1,8'h09, 0,2'd3,8'h01, 1,3'd4,16'h0009, 0};
        tbl[6]  = '{1,0,8'h00, 0,2'd3,8'h01, 0,3'd0,16'h0000, 0};
        tbl[7]  = '{0,1,8'hFF, 1,2'd0,8'hFF, 0,3'd1,16'h00FF, 1};
        tbl[8]  = '{0,1,8'hFF, 1,2'd1,8'hFF, 0,3'd2,16'h01FE, 1};
        tbl[9]  = '{0,1,8'hFF, 1,2'd2,8'hFF, 0,3'd3,16'h02FD, 1};
        tbl[10] = '{0,1,8'hFF, 1,2'd3,8'hFF, 1,3'd4,16'h03FC, 1};
        tbl[11] = '{0,0,8'h00, 0,2'd3,8'hFF, 1,3'd4,16'h03FC, 1};
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].st, tbl[i].vl, tbl[i].d);
            chk("tbl_wen",  {31'd0, bus.wr_en},     {31'd0, tbl[i].e_wen});
            chk("tbl_addr", {30'd0, bus.wr_addr},   {30'd0, tbl[i].e_addr});
            chk("tbl_data", {24'd0, bus.wr_data},   {24'd0, tbl[i].e_data});
            chk("tbl_done", {31'd0, bus.done},      {31'd0, tbl[i].e_done});
            chk("tbl_cnt",  {29'd0, bus.count},     {29'd0, tbl[i].e_cnt});
            chk("tbl_sum",  {16'd0, bus.checksum},  {16'd0, tbl[i].e_sum});
            chk("tbl_err",  {31'd0, bus.err_range}, {31'd0, tbl[i].e_err});
        end

        // Gapped valid with an out-of-range second byte.
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h05);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h0C);
        chk("err_after_0c", {31'd0, bus.err_range}, 32'd1);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h02);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h09);
        chk("gap_done", {31'd0, bus.done}, 32'd1);
        chk("gap_sum", {16'd0, bus.checksum}, 32'h1C);
        chk("ram1_0c", {24'd0, ram[1]}, 32'h0C);

        // Restart mid-load while valid is held.
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h02);
        cycle(1'b0, 1'b1, 8'h03);
        cycle(1'b1, 1'b1, 8'h55);
        cycle(1'b0, 1'b1, 8'h07);
        chk("restart_addr", {30'd0, bus.wr_addr}, 32'd0);
        chk("restart_data", {24'd0, bus.wr_data}, 32'h07);
        chk("restart_cnt", {29'd0, bus.count}, 32'd1);
        chk("restart_sum", {16'd0, bus.checksum}, 32'd7);

        // Reset mid-load at count 2, then a clean reload.
        cycle(1'b0, 1'b1, 8'h01);
        do_reset();
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, 8'(i + 1));
        chk("reload_done", {31'd0, bus.done}, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle($urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7,
                       8'($urandom_range(0, 15)));
        end

        // Final full load so every RAM word has a known value.
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, 8'($urandom_range(0, 255)));
        cycle(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < N; i++) chk("ram_word", {24'd0, ram[i]}, {24'd0, m_ram[i]});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
